// File: rtl/bus_arb_pkg.sv
// Shared bus definitions: arbiter state encodings, default timeout and the
// request bundle steered from the owning master onto the shared bus.
package bus_arb_pkg;

  // Owner states are one-hot so the grant output is the state register itself.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam int unsigned TMO_CYCLES_DEF = 1024;
  localparam int          ADDR_W         = 22;
  localparam int          DATA_W         = 32;

  typedef struct packed {
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
  } bus_req_t;

endpackage

// File: rtl/bus_arb_tmo.sv
// Owner-cycle timeout counter: cleared while the bus is idle, counts stalled
// owner cycles and flags the last allowed one.
module bus_tmo
  import bus_arb_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [15:0] HIT_VAL = 16'(TMO_CYCLES - 1);

  logic [15:0] r_cnt;

  // Saturates instead of wrapping so a stuck count can never re-arm the hit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= 16'd0;
    end else if (en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign hit = (r_cnt == HIT_VAL);

endmodule

// File: rtl/bus_arb.sv
// Two-master round-robin bus arbiter (m0 = CPU, m1 = DMA) with one dead
// IDLE cycle between owners and a sticky owner-stall timeout.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  output logic [DATA_W-1:0] m0_din,
  output logic              m0_ack,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic [DATA_W-1:0] m1_din,
  output logic              m1_ack,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_dout,
  input  logic [DATA_W-1:0] bus_din,
  input  logic              bus_ack,
  output logic [1:0]        grant,
  output logic              tmo_err,
  input  logic              tmo_clr
);

  logic [1:0] r_state;
  logic       r_last;
  logic       r_tmo_err;

  logic [1:0] w_next;
  logic       w_own0;
  logic       w_own1;
  logic       w_owner_stb;
  logic       w_hit;
  logic       w_fire;
  bus_req_t   w_req;

  assign w_own0      = (r_state == ST_OWN0);
  assign w_own1      = (r_state == ST_OWN1);
  assign w_owner_stb = (w_own0 & m0_stb) | (w_own1 & m1_stb);
  // A withdrawn request or a real ack both take precedence over the timeout.
  assign w_fire      = w_owner_stb & ~bus_ack & w_hit;

  bus_tmo #(.TMO_CYCLES(TMO_CYCLES)) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (r_state == ST_IDLE),
    .en  ((w_own0 | w_own1) & ~bus_ack),
    .hit (w_hit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_stb && m1_stb) w_next = r_last ? ST_OWN0 : ST_OWN1;
        else if (m0_stb)      w_next = ST_OWN0;
        else if (m1_stb)      w_next = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (bus_ack || !w_owner_stb || w_fire) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_last = 1 means m1 won most recently, so m0 wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_tmo_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_next == ST_OWN0) r_last <= 1'b0;
      if (r_state == ST_IDLE && w_next == ST_OWN1) r_last <= 1'b1;
      if (w_fire)       r_tmo_err <= 1'b1;
      else if (tmo_clr) r_tmo_err <= 1'b0;
    end
  end

  always_comb begin
    w_req = '0;
    if (w_own0) w_req = '{stb: m0_stb, we: m0_we, addr: m0_addr, dout: m0_dout};
    if (w_own1) w_req = '{stb: m1_stb, we: m1_we, addr: m1_addr, dout: m1_dout};
  end

  assign bus_stb  = w_req.stb;
  assign bus_we   = w_req.we;
  assign bus_addr = w_req.addr;
  assign bus_dout = w_req.dout;

  assign m0_ack  = w_own0 & (bus_ack | w_fire);
  assign m1_ack  = w_own1 & (bus_ack | w_fire);
  assign m0_din  = (w_own0 & w_fire) ? '0 : bus_din;
  assign m1_din  = (w_own1 & w_fire) ? '0 : bus_din;
  assign grant   = r_state;
  assign tmo_err = r_tmo_err;

endmodule
